conv_kxk_stream: RTL and testbench
==================================

# conv_kxk_stream

Parametrised streaming K×K convolution engine for one feature map, replacing the fixed-kernel, fixed-size conv stages. Consumes a raster-order pixel stream with a valid qualifier and runtime-loadable Q-format coefficients, and emits only valid ("interior") outputs with a save strobe. Rounding, bias, saturation and optional ReLU are applied. It sits between the input map buffer (or a previous layer's output) and the pooling/next-layer buffer.

## Interface
- DW, 16: signed data/coef width.
- IMG_W, 96: input map width in pixels.
- IMG_H, 96: input map height in pixels.
- K, 9: kernel side; K ≥ 2, K ≤ IMG_W, K ≤ IMG_H.
- FRAC, 12: fractional bits of coefficients.
- ACC_W, 40: accumulator width; ≥ 2·DW + clog2(K·K).

Ports:
- clk_in  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; high = run a frame, low = idle/abort.
- in_valid  in  1  map_in holds a pixel this cycle.
- map_in  in  DW  signed pixel.
- coef_we  in  1  coefficient write strobe, honoured in IDLE only.
- coef_addr  in  clog2(K·K)  row-major kernel index; values ≥ K·K are ignored.
- coef_data  in  DW  signed Q(DW-FRAC).FRAC coefficient.
- bias  in  DW  signed output-scale bias, sampled in stage 3.
- relu_en  in  1  clamp negative results to 0.
- map_out  out  DW  signed result.
- save  out  1  map_out valid, one cycle per output.
- ready  out  1  high except in DONE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when start = 1. In RUN, each in_valid cycle shifts map_in into the window and advances column x (0..IMG_W-1, wraps) and row y.
- The window is complete when the accepted pixel has x ≥ K-1 and y ≥ K-1. Only then does a valid token enter the pipeline. This gives (IMG_W-K+1)·(IMG_H-K+1) outputs per frame.
- After IMG_W·IMG_H pixels are accepted, the FSM goes RUN → DRAIN and in_valid is ignored. DRAIN → DONE when the pipeline holds no valid token.
- DONE: ready = 0 and holds until start = 0, then DONE → IDLE.
- start = 0 in RUN or DRAIN aborts the frame: pipeline valid bits clear, save = 0 from the next cycle, x/y clear, FSM → IDLE. The line buffer contents need no clearing.
- Coefficient registers reset to 0 and keep their value across frames. A write outside IDLE is dropped.
- Arithmetic:
  - acc = Σ coef[i]·win[i], full precision in ACC_W bits.
  - r = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift, i.e. round-half-up.
  - s = r + bias.
  - Saturate s to [-2^(DW-1), 2^(DW-1)-1].
  - If relu_en = 1 and the result is negative, output 0.
- Window index 0 is the oldest (top-left) pixel; index K·K-1 is the pixel just accepted.

## Timing
- Reset values: map_out = 0, save = 0, ready = 1, FSM = IDLE, x = y = 0, coefficients = 0, pipeline valid bits = 0.
- Fixed pipeline, independent of in_valid gaps: the window is registered on the accept edge.
  - Stage 1: products registered.
  - Stage 2: sum registered.
  - Stage 3: round, bias, saturate, ReLU registered to map_out/save.
- save rises exactly 3 cycles after the accept edge of the completing pixel.
- Back-to-back accepts give one output per cycle.
- save is a single-cycle pulse per output. map_out holds its last value when save = 0, except it is forced to 0 on abort.
- On the last pixel of a frame, the final save occurs 3 cycles later. DONE (ready = 0) follows on the next cycle.
- Asynchronous reset mid-frame forces all reset values immediately. The first frame after reset must be correct.

## Structure
- Package conv_pkg:
  - DW and FRAC defaults.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - sat_dw function (saturate ACC_W → DW).
  - clog2 helper.
- Sub-module conv_line_buffer: K-1 row delay lines of depth IMG_W plus a K×K window register array. Inputs are shift-enable and pixel; outputs are the flattened window. The MAC, rounding and FSM stay in the top.

## Test plan
Bench parameters: IMG_W = 8, IMG_H = 6, K = 3, FRAC = 12.
- Identity kernel: coef[4] = 4096, others 0, bias = 0, pixel = x + 8y, in_valid continuous → 24 saves. First value is 9, saved 3 cycles after pixel 18 is accepted. The sequence is 9..14, 17..22, 25..30, 33..38. Then ready = 0.
- Rounding: all coef = 2048, all pixels = 1 → every output 5 (4.5 rounds up). All pixels = -1 → every output -4.
- Saturation/ReLU: all coef = 32767, pixels = 32767 → 32767. Pixels = -32768 → -32768; with relu_en = 1 → 0. bias = 100 with the identity kernel → outputs shifted by +100.
- Random in_valid gaps (≈50% duty) with the identity case → identical 24-value sequence, each save 3 cycles after its completing accept.
- Abort and reset:
  - start dropped after 30 pixels → no save from the next cycle, ready = 1, FSM idle. A full frame afterwards → correct 24 outputs.
  - rst_n pulsed mid-frame → outputs at reset values immediately.
- Coefficient gating: coef_we with coef_data = 4096 in RUN → ignored (outputs unchanged). The same write in IDLE takes effect next frame. coef_addr = 9 → no register changes. In DONE, ready stays 0 until start = 0, then returns to 1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming KxK convolution engine.
package conv_pkg;

   localparam int DW_DEF   = 16;
   localparam int FRAC_DEF = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Clamp a sign-extended wide result into the signed dw-bit range.
   function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row delay lines of depth IMG_W feeding a KxK window register array.
// Flattened window index r*K+c: index 0 is the oldest (top-left) pixel.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int IMG_W = 96,
   parameter int K     = 9
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              shift_en_i,
   input  logic [DW-1:0]     pix_i,
   output logic [K*K*DW-1:0] win_o
);

   localparam int PW = clog2(IMG_W);

   logic [PW-1:0] ptr_q;
   logic [DW-1:0] line_q [K-1][IMG_W];
   logic [DW-1:0] win_q  [K][K];
   logic [DW-1:0] col    [K];

   // Any starting pointer gives an exact IMG_W-accept delay, so it never needs re-aligning.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (shift_en_i) begin
         ptr_q <= (ptr_q == PW'(IMG_W - 1)) ? '0 : ptr_q + 1'b1;
      end
   end

   always_comb begin
      col[K-1] = pix_i;
      for (int r = 0; r < K - 1; r++) begin
         col[r] = line_q[K-2-r][ptr_q];
      end
   end

   always_ff @(posedge clk_in) begin
      if (shift_en_i) begin
         line_q[0][ptr_q] <= pix_i;
         for (int j = 1; j < K - 1; j++) begin
            line_q[j][ptr_q] <= line_q[j-1][ptr_q];
         end
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_q[r][c] <= win_q[r][c+1];
            end
            win_q[r][K-1] <= col[r];
         end
      end
   end

   always_comb begin
      win_o = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_o[(r*K+c)*DW +: DW] = win_q[r][c];
         end
      end
   end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK convolution: window, product, sum and output stages with
// round-half-up, bias, saturation and optional ReLU.
//
// state | meaning
// IDLE  | waiting for start; coefficient writes accepted
// RUN   | accepting pixels of the current frame
// DRAIN | all pixels taken, flushing the pipeline
// DONE  | frame complete, ready low until start drops
module conv_kxk_stream
   import conv_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int IMG_W = 96,
   parameter int IMG_H = 96,
   parameter int K     = 9,
   parameter int FRAC  = FRAC_DEF,
   parameter int ACC_W = 40
) (
   input  logic                       clk_in,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       in_valid,
   input  logic signed [DW-1:0]       map_in,
   input  logic                       coef_we,
   input  logic [clog2(K*K)-1:0]      coef_addr,
   input  logic signed [DW-1:0]       coef_data,
   input  logic signed [DW-1:0]       bias,
   input  logic                       relu_en,
   output logic signed [DW-1:0]       map_out,
   output logic                       save,
   output logic                       ready
);

   localparam int NK  = K * K;
   localparam int AW  = clog2(NK);
   localparam int XW  = clog2(IMG_W);
   localparam int YW  = clog2(IMG_H);
   localparam int PIX = IMG_W * IMG_H;
   localparam int CW  = clog2(PIX + 1);
   localparam int PW  = 2 * DW;
   localparam int SW  = ACC_W + 2;
   localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);

   state_e state_q, state_d;

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [CW-1:0] cnt_q;
   logic          accept, last_pix, abort, win_full, pipe_busy;
   logic          v0_q, v1_q, v2_q, save_q;

   logic signed [DW-1:0]    map_out_q, res_d;
   logic signed [DW-1:0]    coef_q  [NK];
   logic signed [DW-1:0]    win     [NK];
   logic [NK*DW-1:0]        win_flat;
   logic signed [PW-1:0]    prod_q  [NK];
   logic signed [ACC_W-1:0] sum_q, sum_d;
   logic signed [SW-1:0]    rnd_w, s_w;
   logic signed [63:0]      sat_w;
   logic                    unused_sat;

   assign accept    = (state_q == RUN) && start && in_valid;
   assign last_pix  = accept && (cnt_q == CW'(1));
   assign abort     = !start && ((state_q == RUN) || (state_q == DRAIN));
   assign win_full  = (x_q >= XW'(K - 1)) && (y_q >= YW'(K - 1));
   assign pipe_busy = v0_q | v1_q | v2_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready   = 1'b1;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN: begin
            if (!start)        state_d = IDLE;
            else if (last_pix) state_d = DRAIN;
         end
         DRAIN: begin
            if (!start)          state_d = IDLE;
            else if (!pipe_busy) state_d = DONE;
         end
         DONE: begin
            ready = 1'b0;
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // cnt_q counts down the pixels still owed in this frame.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= CW'(PIX);
      end else if (accept) begin
         cnt_q <= cnt_q - 1'b1;
         if (x_q == XW'(IMG_W - 1)) begin
            x_q <= '0;
            y_q <= (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end else if ((state_q != RUN) || !start) begin
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= CW'(PIX);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NK; i++) coef_q[i] <= '0;
      end else if ((state_q == IDLE) && coef_we) begin
         for (int i = 0; i < NK; i++) begin
            if (coef_addr == AW'(i)) coef_q[i] <= coef_data;
         end
      end
   end

   conv_line_buffer #(
      .DW    (DW),
      .IMG_W (IMG_W),
      .K     (K)
   ) u_line_buffer (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .shift_en_i (accept),
      .pix_i      (map_in),
      .win_o      (win_flat)
   );

   always_comb begin
      for (int i = 0; i < NK; i++) begin
         win[i] = win_flat[i*DW +: DW];
      end
   end

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < NK; i++) begin
         sum_d = sum_d + ACC_W'(prod_q[i]);
      end
   end

   always_ff @(posedge clk_in) begin
      for (int i = 0; i < NK; i++) begin
         prod_q[i] <= PW'(coef_q[i]) * PW'(win[i]);
      end
      sum_q <= sum_d;
   end

   always_comb begin
      rnd_w = (SW'(sum_q) + RND) >>> FRAC;
      s_w   = rnd_w + SW'(bias);
      sat_w = sat_dw(64'(s_w), DW);
      res_d = sat_w[DW-1:0];
      if (relu_en && res_d[DW-1]) res_d = '0;
   end

   assign unused_sat = ^sat_w[63:DW];

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         v0_q      <= 1'b0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         save_q    <= 1'b0;
         map_out_q <= '0;
      end else if (abort) begin
         v0_q      <= 1'b0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         save_q    <= 1'b0;
         map_out_q <= '0;
      end else begin
         v0_q   <= accept && win_full;
         v1_q   <= v0_q;
         v2_q   <= v1_q;
         save_q <= v2_q;
         if (v2_q) map_out_q <= res_d;
      end
   end

   assign map_out = map_out_q;
   assign save    = save_q;

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Directed bench for conv_kxk_stream on an 8x6 map with a 3x3 kernel.
module tb_conv_kxk_stream;

   localparam int DW    = 16;
   localparam int IMG_W = 8;
   localparam int IMG_H = 6;
   localparam int K     = 3;
   localparam int FRAC  = 12;
   localparam int ACC_W = 40;
   localparam int AW    = 4;

   logic                 clk_in   = 1'b0;
   logic                 rst_n    = 1'b0;
   logic                 start    = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] map_in   = '0;
   logic                 coef_we  = 1'b0;
   logic [AW-1:0]        coef_addr = '0;
   logic signed [DW-1:0] coef_data = '0;
   logic signed [DW-1:0] bias     = '0;
   logic                 relu_en  = 1'b0;
   logic signed [DW-1:0] map_out;
   logic                 save;
   logic                 ready;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int sv_q[$];
   int sc_q[$];
   int ev_q[$];
   int ec_q[$];

   conv_kxk_stream #(
      .DW    (DW),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .K     (K),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .map_in    (map_in),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .bias      (bias),
      .relu_en   (relu_en),
      .map_out   (map_out),
      .save      (save),
      .ready     (ready)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (save === 1'b1) begin
         sv_q.push_back(int'(map_out));
         sc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wcoef(input int a, input int d);
      @(negedge clk_in);
      coef_we   = 1'b1;
      coef_addr = AW'(a);
      coef_data = DW'(d);
      @(negedge clk_in);
      coef_we   = 1'b0;
   endtask

   // Streams n raster pixels; records expected value and accept cycle of each completing pixel.
   task automatic drive(input bit ramp, input int pix_c, input int exp_v,
                        input bit gaps, input bit wr_run, input int n);
      int idx;
      int guard;
      int x;
      int y;
      idx   = 0;
      guard = 0;
      sv_q.delete();
      sc_q.delete();
      ev_q.delete();
      ec_q.delete();
      @(negedge clk_in);
      start = 1'b1;
      while (idx < n && guard < 1000) begin
         @(negedge clk_in);
         guard++;
         coef_we = 1'b0;
         if (gaps && $urandom_range(1, 0) == 0) begin
            in_valid = 1'b0;
         end else begin
            x = idx % IMG_W;
            y = idx / IMG_W;
            in_valid = 1'b1;
            map_in   = ramp ? DW'(x + IMG_W * y) : DW'(pix_c);
            if (x >= K - 1 && y >= K - 1) begin
               ev_q.push_back(ramp ? (x - 1) + IMG_W * (y - 1) + exp_v : exp_v);
               ec_q.push_back(cyc + 1);
            end
            if (wr_run && idx == 20) begin
               coef_we   = 1'b1;
               coef_addr = AW'(0);
               coef_data = DW'(4096);
            end
            idx++;
         end
      end
      @(negedge clk_in);
      in_valid = 1'b0;
      coef_we  = 1'b0;
   endtask

   task automatic frame(input string tag, input bit ramp, input int pix_c, input int exp_v,
                        input bit gaps, input bit wr_run);
      int guard;
      guard = 0;
      drive(ramp, pix_c, exp_v, gaps, wr_run, IMG_W * IMG_H);
      while (ready !== 1'b0 && guard < 100) begin
         @(negedge clk_in);
         guard++;
      end
      chk({tag, " done_reached"}, ready, 0);
      chk({tag, " n_saves"}, sv_q.size(), 24);
      for (int i = 0; i < sv_q.size() && i < ev_q.size(); i++) begin
         chk($sformatf("%s val%0d", tag, i), sv_q[i], ev_q[i]);
         chk($sformatf("%s lat%0d", tag, i), sc_q[i] - ec_q[i], 3);
      end
      if (sc_q.size() > 0) chk({tag, " done_cycle"}, cyc - sc_q[sc_q.size()-1], 1);
      repeat (3) @(negedge clk_in);
      chk({tag, " done_hold"}, ready, 0);
      start = 1'b0;
      @(negedge clk_in);
      chk({tag, " ready_back"}, ready, 1);
   endtask

   initial begin
      int ab_cyc;
      int n_late;
      int guard;

      #12;
      chk("rst map_out", map_out, 0);
      chk("rst save", save, 0);
      chk("rst ready", ready, 1);
      @(negedge clk_in);
      rst_n = 1'b1;

      wcoef(4, 4096);
      frame("ident", 1'b1, 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 9; i++) wcoef(i, 2048);
      frame("rnd_pos", 1'b0, 1, 5, 1'b0, 1'b0);
      frame("rnd_neg", 1'b0, -1, -4, 1'b0, 1'b0);

      for (int i = 0; i < 9; i++) wcoef(i, 32767);
      frame("sat_pos", 1'b0, 32767, 32767, 1'b0, 1'b0);
      frame("sat_neg", 1'b0, -32768, -32768, 1'b0, 1'b0);
      relu_en = 1'b1;
      frame("relu", 1'b0, -32768, 0, 1'b0, 1'b0);
      relu_en = 1'b0;

      for (int i = 0; i < 9; i++) wcoef(i, (i == 4) ? 4096 : 0);
      bias = DW'(100);
      frame("bias", 1'b1, 0, 100, 1'b0, 1'b0);
      bias = '0;
      frame("gaps", 1'b1, 0, 0, 1'b1, 1'b0);

      frame("we_run", 1'b1, 0, 0, 1'b0, 1'b1);
      wcoef(0, 4096);
      frame("we_idle", 1'b0, 1, 2, 1'b0, 1'b0);
      wcoef(9, 4096);
      frame("addr9", 1'b0, 1, 2, 1'b0, 1'b0);
      wcoef(0, 0);

      drive(1'b1, 0, 0, 1'b0, 1'b0, 30);
      start  = 1'b0;
      ab_cyc = cyc + 1;
      @(negedge clk_in);
      chk("abort save", save, 0);
      chk("abort ready", ready, 1);
      chk("abort map_out", map_out, 0);
      repeat (6) @(negedge clk_in);
      n_late = 0;
      foreach (sc_q[i]) if (sc_q[i] >= ab_cyc) n_late++;
      chk("abort late_saves", n_late, 0);
      chk("abort idle_ready", ready, 1);
      frame("post_abort", 1'b1, 0, 0, 1'b0, 1'b0);

      drive(1'b1, 0, 0, 1'b0, 1'b0, 22);
      guard = 0;
      while (save !== 1'b1 && guard < 10) begin
         @(negedge clk_in);
         guard++;
      end
      chk("pre_rst save", save, 1);
      #1;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      chk("mid_rst map_out", map_out, 0);
      chk("mid_rst save", save, 0);
      chk("mid_rst ready", ready, 1);
      @(negedge clk_in);
      rst_n = 1'b1;
      frame("zero_coef", 1'b0, 7, 0, 1'b0, 1'b0);
      wcoef(4, 4096);
      frame("post_rst", 1'b1, 0, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
